seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised multiplexed seven-segment display driver for the board's common-anode digit displays. It time-multiplexes DIGITS BCD nibbles across active-low anodes, decodes each nibble to active-low cathodes, and drives the per-digit decimal point. It adds frame-coherent input snapshots, leading-zero blanking and 16-level brightness dimming. It sits between the counter/FSM datapath and the top-level display pins.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 1024, clock cycles per digit slot; power of two, ≥16.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- bcd_in  input  4*DIGITS  digit values; nibble i drives digit i; digit 0 is rightmost.
- dp_in  input  DIGITS  decimal point request per digit, active high.
- blank_en  input  1  enables leading-zero blanking.
- bright  input  4  brightness level; 15 is full on, 0 is 1/16 duty.
- seg_anode  output  DIGITS  anode enables, active low.
- seg_cathode  output  7  segments {g,f,e,d,c,b,a}, active low.
- seg_dp  output  1  decimal point, active low.
- digit_idx  output  $clog2(DIGITS)  index of the digit currently displayed.

## Operation
- Prescaler `pre` counts 0..REFRESH_DIV-1, then wraps to 0.
- Digit index `idx` advances by one on each prescaler wrap. It wraps from DIGITS-1 to 0.
- Frame snapshot `snap_bcd` and `snap_dp` load from bcd_in and dp_in on the cycle where pre == REFRESH_DIV-1 and idx == DIGITS-1. Input changes are only visible from the next frame, so the display never tears.
- Dimming gate: `on` = (pre[MSB:MSB-3] <= bright). Anodes are released outside this window. Cathodes and dp stay valid throughout the slot.
- Blanking:
  - Digit i (i ≥ 1) is blanked when blank_en = 1 and snapshot digits DIGITS-1..i are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives all cathodes high, but its dp still follows snap_dp.
- Decode:
  - Values 0..9 map to the standard glyphs, e.g. 0 → 7'b1000000 and 1 → 7'b1111001.
  - Values 10..15 are handled per the Configuration section.
- Anode drive: seg_anode = all ones, except bit idx, which is 0 when `on` is true.

## Timing
- All outputs are registered and derived from the current pre, idx and snapshot, with 1-cycle latency.
- Reset values:
  - seg_anode = all ones; seg_cathode = 7'h7F; seg_dp = 1; digit_idx = 0.
  - pre = 0; idx = 0; snap_bcd = 0; snap_dp = 0.
- First frame after reset displays the zero snapshot: digit 0 shows "0"; the others show "0" when blank_en = 0 and are blank when blank_en = 1.
- A digit slot lasts exactly REFRESH_DIV cycles. A full frame lasts DIGITS*REFRESH_DIV cycles.
- Index advance and snapshot load on the same edge: the new idx is decoded from the newly loaded snapshot.
- bright changes take effect on the next cycle. There is no frame alignment.
- Reset asserted mid-frame forces the reset values immediately (asynchronously). Scanning restarts at digit 0 with pre = 0.

## Configuration
- SEG_HEX_EN defined: values 10..15 decode to hex glyphs A, b, C, d, E, F (A → 7'b0001000, F → 7'b0001110).
- SEG_HEX_EN undefined: values 10..15 decode to a dash, segment g only (7'b0111111).
- In both cases, for blanking purposes a nibble counts as zero only if it equals 4'h0.

## Structure
- Package `seg_pkg`: glyph constants (SEG_BLANK, SEG_DASH, digit glyphs 0..F) and the cathode bit-order definition.
- Sub-module `seg_decoder`: combinational 4-bit to 7-bit glyph decode, honouring SEG_HEX_EN. The scanner instantiates it once on the selected snapshot nibble.
- Scanner holds the prescaler, index counter, snapshot registers, blanking logic, dimming gate and output registers.

## Test plan
All scenarios use DIGITS=4 and REFRESH_DIV=16.
- Reset, then bcd_in=16'h1234, blank_en=0, bright=15 → frame 1 shows all "0". From frame 2, digit_idx 0..3 show cathodes 4, 3, 2, 1, with anodes 1110, 1101, 1011, 0111, each held 16 cycles.
- bcd_in=16'h0042, blank_en=1 → digits 3 and 2 are blank (cathode 7'h7F); digits 1 and 0 show 4 and 2. bcd_in=16'h0000 → only digit 0 shows "0".
- bright=3 → anode low for pre 0..3 only (4 of 16 cycles) in each slot. bright=15 → low for all 16 cycles.
- Change bcd_in mid-frame (at idx=1) → display is unchanged until the snapshot at the frame end. The new value appears at the next idx=0.
- bcd_in=16'h00AF → with SEG_HEX_EN, digits 1 and 0 show A and F. Without it, both show 7'b0111111.
- Assert rst at idx=2, pre=7 → outputs reach their reset values before the next edge. After release, digit_idx=0 and the slot lasts a full 16 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment glyph constants, cathode bit order and nibble-to-glyph lookup.
package seg_pkg;
  typedef logic [6:0] seg_t;
  typedef enum int {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} seg_bit_e;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = ~(seg_t'(1) << SEG_G);
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_HEX_A = 7'h08;
  localparam seg_t SEG_HEX_B = 7'h03;
  localparam seg_t SEG_HEX_C = 7'h46;
  localparam seg_t SEG_HEX_D = 7'h21;
  localparam seg_t SEG_HEX_E = 7'h06;
  localparam seg_t SEG_HEX_F = 7'h0E;
  function automatic seg_t glyph_of(logic [3:0] v);
    case (v)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_HEX_A;
      4'hB: return SEG_HEX_B;
      4'hC: return SEG_HEX_C;
      4'hD: return SEG_HEX_D;
      4'hE: return SEG_HEX_E;
      default: return SEG_HEX_F;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_if: digit data in and display pins out; slave is the scanner, master is the datapath/pin side.
interface seven_seg_if
  import seg_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd_in;
  logic [DIGITS-1:0] dp_in;
  logic blank_en;
  logic [3:0] bright;
  logic [DIGITS-1:0] seg_anode;
  seg_t seg_cathode;
  logic seg_dp;
  logic [$clog2(DIGITS)-1:0] digit_idx;
  modport master (
    output bcd_in, dp_in, blank_en, bright,
    input seg_anode, seg_cathode, seg_dp, digit_idx
  );
  modport slave (
    input bcd_in, dp_in, blank_en, bright,
    output seg_anode, seg_cathode, seg_dp, digit_idx
  );
endinterface

// File: rtl/seg_decoder.sv
// seg_decoder: 4-bit to active-low 7-segment glyph; SEG_HEX_EN selects hex glyphs for 10..15, else a dash.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] val,
  output seg_t       glyph
);
`ifdef SEG_HEX_EN
  assign glyph = glyph_of(val);
`else
  assign glyph = val > 4'd9 ? SEG_DASH : glyph_of(val);
`endif
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode display driver with frame snapshots, leading-zero blanking
// and 16-level dimming; SEG_HEX_EN (in seg_decoder) enables hex glyphs for 10..15.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1024
) (
  input logic clk,
  input logic rst,
  seven_seg_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  if (DIGITS < 2 || DIGITS > 8 || REFRESH_DIV < 16 || (REFRESH_DIV & (REFRESH_DIV - 1)) != 0) begin : g_bad_param
    $error("seven_seg_scanner: unsupported DIGITS/REFRESH_DIV");
  end
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] snap_bcd;
  logic [DIGITS-1:0] snap_dp;
  logic [DIGITS:1] zero_run;
  logic [DIGITS-1:0] blank;
  logic wrap, frame_end, on;
  logic [3:0] nib;
  seg_t glyph;
  assign wrap = pre == PW'(REFRESH_DIV - 1);
  assign frame_end = wrap && idx == IW'(DIGITS - 1);
  assign on = pre[PW-1 -: 4] <= bus.bright;
  assign nib = snap_bcd[{idx, 2'b00} +: 4];
  // zero_run[i]: blanking enabled and every snapshot digit from the top down to i is zero
  assign zero_run[DIGITS] = bus.blank_en;
  for (genvar i = 1; i < DIGITS; i++) begin : g_zero
    assign zero_run[i] = zero_run[i+1] && snap_bcd[4*i +: 4] == 4'h0;
  end
  assign blank = {zero_run[DIGITS-1:1], 1'b0};
  seg_decoder u_dec (
    .val   (nib),
    .glyph (glyph)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      idx      <= '0;
      snap_bcd <= '0;
      snap_dp  <= '0;
    end else begin
      pre <= wrap ? '0 : pre + PW'(1);
      if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      if (frame_end) begin
        snap_bcd <= bus.bcd_in;
        snap_dp  <= bus.dp_in;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg_anode   <= '1;
      bus.seg_cathode <= SEG_BLANK;
      bus.seg_dp      <= 1'b1;
      bus.digit_idx   <= '0;
    end else begin
      bus.seg_anode   <= on ? ~(DIGITS'(1) << idx) : '1;
      bus.seg_cathode <= blank[idx] ? SEG_BLANK : glyph;
      bus.seg_dp      <= ~snap_dp[idx];
      bus.digit_idx   <= idx;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scanning, snapshots, blanking, dimming, hex/dash decode and async reset.
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seven_seg_if #(.DIGITS(4)) bus();
  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  int tests = 0;
  int failed = 0;
  int cyc = 0;
  logic [6:0] g [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // after edge k (counted from reset release) outputs reflect pre=(k-1)%16, idx=((k-1)/16)%4
  task automatic step_to(int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask
  function automatic int frame_after(int c);
    return (c / 64 + 1) * 64 + 1;
  endfunction
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask
  task automatic test_reset();
    bus.bcd_in = 16'h1234;
    bus.dp_in = 4'b0000;
    bus.blank_en = 1'b0;
    bus.bright = 4'd15;
    rst = 1'b1;
    #12;
    tests++; if (bus.seg_anode !== 4'hF) begin failed++; $display("FAIL reset_anode got %h exp %h", bus.seg_anode, 4'hF); end
    tests++; if (bus.seg_cathode !== 7'h7F) begin failed++; $display("FAIL reset_cathode got %h exp %h", bus.seg_cathode, 7'h7F); end
    tests++; if (bus.seg_dp !== 1'b1) begin failed++; $display("FAIL reset_dp got %b exp 1", bus.seg_dp); end
    tests++; if (bus.digit_idx !== 2'd0) begin failed++; $display("FAIL reset_idx got %0d exp 0", bus.digit_idx); end
    release_rst();
  endtask
  task automatic test_scan();
    logic [3:0] an;
    for (int s = 0; s < 4; s++) begin
      an = ~(4'b0001 << s);
      step_to(16 * s + 1);
      tests++; if (bus.digit_idx !== 2'(s)) begin failed++; $display("FAIL scan1_idx s=%0d got %0d exp %0d", s, bus.digit_idx, s); end
      tests++; if (bus.seg_anode !== an) begin failed++; $display("FAIL scan1_anode s=%0d got %b exp %b", s, bus.seg_anode, an); end
      tests++; if (bus.seg_cathode !== 7'h40) begin failed++; $display("FAIL scan1_cath s=%0d got %h exp 40", s, bus.seg_cathode); end
    end
    for (int s = 0; s < 4; s++) begin
      an = ~(4'b0001 << s);
      step_to(65 + 16 * s);
      tests++; if (bus.seg_cathode !== g[4-s]) begin failed++; $display("FAIL scan2_cath s=%0d got %h exp %h", s, bus.seg_cathode, g[4-s]); end
      tests++; if (bus.seg_anode !== an) begin failed++; $display("FAIL scan2_anode s=%0d got %b exp %b", s, bus.seg_anode, an); end
      step_to(80 + 16 * s);
      tests++; if (bus.digit_idx !== 2'(s) || bus.seg_anode !== an) begin failed++; $display("FAIL scan2_hold s=%0d got idx %0d an %b exp idx %0d an %b", s, bus.digit_idx, bus.seg_anode, s, an); end
    end
  endtask
  task automatic test_blanking();
    int base;
    logic [6:0] exp_c [4];
    logic [3:0] dpv;
    bus.bcd_in = 16'h0042;
    bus.blank_en = 1'b1;
    dpv = 4'b0100;
    bus.dp_in = dpv;
    base = frame_after(cyc);
    exp_c = '{7'h24, 7'h19, 7'h7F, 7'h7F};
    for (int s = 0; s < 4; s++) begin
      step_to(base + 16 * s);
      tests++; if (bus.seg_cathode !== exp_c[s]) begin failed++; $display("FAIL blank42_cath s=%0d got %h exp %h", s, bus.seg_cathode, exp_c[s]); end
      tests++; if (bus.seg_dp !== ~dpv[s]) begin failed++; $display("FAIL blank42_dp s=%0d got %b exp %b", s, bus.seg_dp, ~dpv[s]); end
    end
    bus.bcd_in = 16'h0000;
    bus.dp_in = 4'b0000;
    base = frame_after(cyc);
    exp_c = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    for (int s = 0; s < 4; s++) begin
      step_to(base + 16 * s);
      tests++; if (bus.seg_cathode !== exp_c[s]) begin failed++; $display("FAIL blank0_cath s=%0d got %h exp %h", s, bus.seg_cathode, exp_c[s]); end
    end
  endtask
  task automatic test_dimming();
    int base, lvl, s, lows;
    logic [3:0] an;
    logic [3:0] levels [3] = '{4'd3, 4'd15, 4'd0};
    bus.blank_en = 1'b0;
    for (int l = 0; l < 3; l++) begin
      bus.bright = levels[l];
      lvl = int'(levels[l]);
      base = (cyc / 16 + 1) * 16 + 1;
      lows = 0;
      for (int p = 0; p < 16; p++) begin
        step_to(base + p);
        s = ((base + p - 1) / 16) % 4;
        an = p <= lvl ? ~(4'b0001 << s) : 4'hF;
        if (bus.seg_anode != 4'hF) lows++;
        tests++; if (bus.seg_anode !== an) begin failed++; $display("FAIL dim_anode bright=%0d p=%0d got %b exp %b", lvl, p, bus.seg_anode, an); end
        tests++; if (bus.seg_cathode !== 7'h40) begin failed++; $display("FAIL dim_cath bright=%0d p=%0d got %h exp 40", lvl, p, bus.seg_cathode); end
      end
      tests++; if (lows != lvl + 1) begin failed++; $display("FAIL dim_duty bright=%0d got %0d exp %0d", lvl, lows, lvl + 1); end
    end
    bus.bright = 4'd15;
  endtask
  task automatic test_midframe();
    int base;
    bus.bcd_in = 16'h1234;
    base = frame_after(cyc);
    step_to(base + 16);
    bus.bcd_in = 16'h5678;
    step_to(base + 32);
    tests++; if (bus.seg_cathode !== g[2]) begin failed++; $display("FAIL mid_idx2 got %h exp %h", bus.seg_cathode, g[2]); end
    step_to(base + 48);
    tests++; if (bus.seg_cathode !== g[1]) begin failed++; $display("FAIL mid_idx3 got %h exp %h", bus.seg_cathode, g[1]); end
    step_to(base + 64);
    tests++; if (bus.seg_cathode !== g[8] || bus.digit_idx !== 2'd0) begin failed++; $display("FAIL mid_new0 got %h idx %0d exp %h idx 0", bus.seg_cathode, bus.digit_idx, g[8]); end
    step_to(base + 80);
    tests++; if (bus.seg_cathode !== g[7]) begin failed++; $display("FAIL mid_new1 got %h exp %h", bus.seg_cathode, g[7]); end
  endtask
  task automatic test_hex();
    int base;
    logic [6:0] exp_c [4];
    bus.bcd_in = 16'h00AF;
    bus.blank_en = 1'b1;
    base = frame_after(cyc);
`ifdef SEG_HEX_EN
    exp_c = '{7'h0E, 7'h08, 7'h7F, 7'h7F};
`else
    exp_c = '{7'h3F, 7'h3F, 7'h7F, 7'h7F};
`endif
    for (int s = 0; s < 4; s++) begin
      step_to(base + 16 * s);
      tests++; if (bus.seg_cathode !== exp_c[s]) begin failed++; $display("FAIL hex_cath s=%0d got %h exp %h", s, bus.seg_cathode, exp_c[s]); end
    end
  endtask
  task automatic test_async_reset();
    step_to((cyc / 64 + 1) * 64 + 39);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.seg_anode !== 4'hF) begin failed++; $display("FAIL arst_anode got %b exp 1111", bus.seg_anode); end
    tests++; if (bus.seg_cathode !== 7'h7F) begin failed++; $display("FAIL arst_cath got %h exp 7f", bus.seg_cathode); end
    tests++; if (bus.seg_dp !== 1'b1) begin failed++; $display("FAIL arst_dp got %b exp 1", bus.seg_dp); end
    tests++; if (bus.digit_idx !== 2'd0) begin failed++; $display("FAIL arst_idx got %0d exp 0", bus.digit_idx); end
    #3;
    release_rst();
    step_to(1);
    tests++; if (bus.seg_cathode !== 7'h40 || bus.seg_anode !== 4'b1110) begin failed++; $display("FAIL arst_first got %h an %b exp 40 an 1110", bus.seg_cathode, bus.seg_anode); end
    step_to(16);
    tests++; if (bus.digit_idx !== 2'd0) begin failed++; $display("FAIL arst_slot_end got %0d exp 0", bus.digit_idx); end
    step_to(17);
    tests++; if (bus.digit_idx !== 2'd1 || bus.seg_cathode !== 7'h7F) begin failed++; $display("FAIL arst_next got idx %0d cath %h exp idx 1 cath 7f", bus.digit_idx, bus.seg_cathode); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_dimming();
    test_midframe();
    test_hex();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
